// File: rtl/decode_pkg.sv
// Shared encodings for the decode stage: opcodes, format codes, buffer states.
package decode_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OPC_W    = 7;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned F3_W     = 3;
    localparam int unsigned F7_W     = 7;

    localparam logic [OPC_W-1:0] OPC_LUI        = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC      = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL        = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR       = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH     = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD       = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE      = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM     = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP         = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM_32  = 7'b0011011;
    localparam logic [OPC_W-1:0] OPC_OP_32      = 7'b0111011;
    localparam logic [OPC_W-1:0] OPC_MISC_MEM   = 7'b0001111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM     = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } fmt_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    // XLEN-independent part of a buffered entry
    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rd;
        logic [F3_W-1:0]  funct3;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [F7_W-1:0]  funct7;
        fmt_e             fmt;
        logic             illegal;
    } dec_fields_t;

    // Value held by an empty or freshly reset entry
    function automatic dec_fields_t fields_reset();
        dec_fields_t f;
        f         = '0;
        f.fmt     = FMT_NONE;
        f.illegal = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate / format / legality decode of one instruction word.
module imm_gen
    import decode_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter bit          RV64_OPS = 1'b0
) (
    input  logic [INSTR_W-1:0] i_instr,
    output logic [XLEN-1:0]    o_imm_c,
    output fmt_e               o_fmt_c,
    output logic               o_illegal_c
);

    // 64-bit-only encodings are accepted only on a 64-bit datapath with RV64_OPS set
    localparam bit RV64 = RV64_OPS && (XLEN == 64);

    logic [OPC_W-1:0] w_op;
    logic [F3_W-1:0]  w_f3;
    logic [F7_W-1:0]  w_f7;
    logic             w_op_f7_bad;
    logic [31:0]      w_imm32;
    fmt_e             w_fmt;
    logic             w_illegal;

    assign w_op = i_instr[6:0];
    assign w_f3 = i_instr[14:12];
    assign w_f7 = i_instr[31:25];

    // Register-register ops only allow funct7 0 or the SUB/SRA alternate encoding
    assign w_op_f7_bad = !((w_f7 == 7'b0000000) ||
                           ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));

    // Classify opcode into format and legality
    always_comb begin
        w_fmt     = FMT_NONE;
        w_illegal = 1'b0;
        case (w_op)
            OPC_OP:        begin w_fmt = FMT_R; w_illegal = w_op_f7_bad;          end
            OPC_OP_32:     begin w_fmt = FMT_R; w_illegal = !RV64 || w_op_f7_bad; end
            OPC_OP_IMM:    begin w_fmt = FMT_I;                                   end
            OPC_OP_IMM_32: begin w_fmt = FMT_I; w_illegal = !RV64;                end
            OPC_LOAD: begin
                w_fmt     = FMT_I;
                w_illegal = (w_f3 == 3'b111) ||
                            (((w_f3 == 3'b011) || (w_f3 == 3'b110)) && !RV64);
            end
            OPC_STORE: begin
                w_fmt     = FMT_S;
                w_illegal = (w_f3 > 3'b011) || ((w_f3 == 3'b011) && !RV64);
            end
            OPC_JALR:      begin w_fmt = FMT_I; w_illegal = (w_f3 != 3'b000);     end
            OPC_SYSTEM:    begin w_fmt = FMT_I;                                   end
            OPC_MISC_MEM:  begin w_fmt = FMT_I;                                   end
            OPC_BRANCH: begin
                w_fmt     = FMT_B;
                w_illegal = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            OPC_LUI, OPC_AUIPC: begin w_fmt = FMT_U; end
            OPC_JAL:            begin w_fmt = FMT_J; end
            default:            begin w_illegal = 1'b1; end
        endcase
        if (i_instr[1:0] != 2'b11) begin
            w_illegal = 1'b1;
        end
    end

    // Assemble the 32-bit immediate; illegal entries carry zero and no format
    always_comb begin
        w_imm32     = '0;
        o_fmt_c     = w_fmt;
        o_illegal_c = w_illegal;
        case (w_fmt)
            FMT_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U: w_imm32 = {i_instr[31:12], 12'b0};
            FMT_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
        if (w_illegal) begin
            w_imm32 = '0;
            o_fmt_c = FMT_NONE;
        end
    end

    assign o_imm_c = XLEN'($signed(w_imm32));

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes at the input and holds results in a main + skid buffer.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter bit          RV64_OPS = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [XLEN-1:0]    in_pc,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [OPC_W-1:0]   out_opcode,
    output logic [REG_W-1:0]   out_rd,
    output logic [F3_W-1:0]    out_funct3,
    output logic [REG_W-1:0]   out_rs1,
    output logic [REG_W-1:0]   out_rs2,
    output logic [F7_W-1:0]    out_funct7,
    output logic [XLEN-1:0]    out_imm,
    output logic [2:0]         out_fmt,
    output logic               out_illegal
);

    logic [XLEN-1:0] w_imm;
    fmt_e            w_fmt;
    logic            w_illegal;
    dec_fields_t     w_fields;

    buf_state_e      r_state;
    buf_state_e      w_state_nxt;
    logic            r_in_ready;
    logic            r_out_valid;
    dec_fields_t     r_main_f;
    dec_fields_t     r_skid_f;
    logic [XLEN-1:0] r_main_pc;
    logic [XLEN-1:0] r_skid_pc;
    logic [XLEN-1:0] r_main_imm;
    logic [XLEN-1:0] r_skid_imm;

    logic            w_push;
    logic            w_pop;
    logic            w_load_main;
    logic            w_load_skid;
    logic            w_main_from_skid;

    imm_gen #(
        .XLEN     (XLEN),
        .RV64_OPS (RV64_OPS)
    ) u_imm_gen (
        .i_instr     (in_instr),
        .o_imm_c     (w_imm),
        .o_fmt_c     (w_fmt),
        .o_illegal_c (w_illegal)
    );

    // Raw fields of the incoming word plus its decode
    always_comb begin
        w_fields         = fields_reset();
        w_fields.opcode  = in_instr[6:0];
        w_fields.rd      = in_instr[11:7];
        w_fields.funct3  = in_instr[14:12];
        w_fields.rs1     = in_instr[19:15];
        w_fields.rs2     = in_instr[24:20];
        w_fields.funct7  = in_instr[31:25];
        w_fields.fmt     = w_fmt;
        w_fields.illegal = w_illegal;
    end

    // Flush masks both handshakes so a flushed cycle neither accepts nor retires
    assign w_push = in_valid && r_in_ready && !flush;
    assign w_pop  = r_out_valid && out_ready && !flush;

    // Buffer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath load controls
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        if (flush) begin
            w_state_nxt = BUF_EMPTY;
        end else begin
            case (r_state)
                BUF_EMPTY: begin
                    if (w_push) begin
                        w_load_main = 1'b1;
                        w_state_nxt = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    case ({w_push, w_pop})
                        2'b11:   w_load_main = 1'b1;
                        2'b10: begin
                            w_load_skid = 1'b1;
                            w_state_nxt = BUF_TWO;
                        end
                        2'b01:   w_state_nxt = BUF_EMPTY;
                        default: w_state_nxt = BUF_ONE;
                    endcase
                end
                BUF_TWO: begin
                    if (w_pop) begin
                        w_main_from_skid = 1'b1;
                        w_state_nxt      = BUF_ONE;
                    end
                end
                default: w_state_nxt = BUF_EMPTY;
            endcase
        end
    end

    // Handshake flags registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt != BUF_TWO);
            r_out_valid <= (w_state_nxt != BUF_EMPTY);
        end
    end

    // Entry storage: main feeds the outputs, skid absorbs one stalled push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_f   <= fields_reset();
            r_skid_f   <= fields_reset();
            r_main_pc  <= '0;
            r_skid_pc  <= '0;
            r_main_imm <= '0;
            r_skid_imm <= '0;
        end else begin
            if (w_load_main) begin
                r_main_f   <= w_fields;
                r_main_pc  <= in_pc;
                r_main_imm <= w_imm;
            end else if (w_main_from_skid) begin
                r_main_f   <= r_skid_f;
                r_main_pc  <= r_skid_pc;
                r_main_imm <= r_skid_imm;
            end
            if (w_load_skid) begin
                r_skid_f   <= w_fields;
                r_skid_pc  <= in_pc;
                r_skid_imm <= w_imm;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_pc      = r_main_pc;
    assign out_opcode  = r_main_f.opcode;
    assign out_rd      = r_main_f.rd;
    assign out_funct3  = r_main_f.funct3;
    assign out_rs1     = r_main_f.rs1;
    assign out_rs2     = r_main_f.rs2;
    assign out_funct7  = r_main_f.funct7;
    assign out_imm     = r_main_imm;
    assign out_fmt     = r_main_f.fmt;
    assign out_illegal = r_main_f.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: 32-bit instance plus two 64-bit instances.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;

    logic        d_in_valid = 1'b0;
    logic [31:0] d_instr = '0;
    logic [63:0] d_pc = '0;
    logic        d_out_ready = 1'b0;

    logic        a_in_ready, a_out_valid, a_illegal;
    logic [63:0] a_pc, a_imm;
    logic [6:0]  a_opcode, a_funct7;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [2:0]  a_funct3, a_fmt;

    logic        b_in_ready, b_out_valid, b_illegal;
    logic [63:0] b_pc, b_imm;
    logic [6:0]  b_opcode, b_funct7;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [2:0]  b_funct3, b_fmt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .RV64_OPS(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    decode_stage #(.XLEN(64), .RV64_OPS(1'b0)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(a_in_ready),
        .in_instr(d_instr), .in_pc(d_pc), .flush(1'b0),
        .out_valid(a_out_valid), .out_ready(d_out_ready), .out_pc(a_pc),
        .out_opcode(a_opcode), .out_rd(a_rd), .out_funct3(a_funct3),
        .out_rs1(a_rs1), .out_rs2(a_rs2), .out_funct7(a_funct7),
        .out_imm(a_imm), .out_fmt(a_fmt), .out_illegal(a_illegal)
    );

    decode_stage #(.XLEN(64), .RV64_OPS(1'b1)) dut64r (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(b_in_ready),
        .in_instr(d_instr), .in_pc(d_pc), .flush(1'b0),
        .out_valid(b_out_valid), .out_ready(d_out_ready), .out_pc(b_pc),
        .out_opcode(b_opcode), .out_rd(b_rd), .out_funct3(b_funct3),
        .out_rs1(b_rs1), .out_rs2(b_rs2), .out_funct7(b_funct7),
        .out_imm(b_imm), .out_fmt(b_fmt), .out_illegal(b_illegal)
    );

    // Decode vectors pushed back-to-back through the 32-bit instance
    logic [31:0] tv_instr [0:11] = '{
        32'h00000013, 32'h40000033, 32'h40001033, 32'h000010E7,
        32'h00002063, 32'h0000B083, 32'h00003023, 32'h00112223,
        32'h0040006F, 32'hFFFFF037, 32'h0000000F, 32'h0000001B };
    logic [2:0]  tv_fmt [0:11] = '{
        3'd1, 3'd0, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd2, 3'd5, 3'd4, 3'd1, 3'd6 };
    logic [31:0] tv_imm [0:11] = '{
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4,
        32'h4, 32'hFFFFF000, 32'h0, 32'h0 };
    logic        tv_ill [0:11] = '{
        1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1 };

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent;
        int got;
        logic saw_full;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_fmt",       64'(out_fmt),   64'd6);
        chk("rst_illegal",   64'(out_illegal), 64'd0);
        chk("rst_imm",       64'(out_imm),   64'd0);
        chk("rst64_valid",   64'(a_out_valid), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_in_ready",  64'(in_ready),  64'd1);
        chk("rel_out_valid", 64'(out_valid), 64'd0);

        // addi x1,x0,-1
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'hFFF00093;
        in_pc     = 32'h100;
        tick();
        chk("addi_valid",   64'(out_valid),   64'd1);
        chk("addi_rd",      64'(out_rd),      64'd1);
        chk("addi_fmt",     64'(out_fmt),     64'd1);
        chk("addi_imm",     64'(out_imm),     64'hFFFFFFFF);
        chk("addi_illegal", 64'(out_illegal), 64'd0);
        chk("addi_pc",      64'(out_pc),      64'h100);
        chk("addi_opcode",  64'(out_opcode),  64'h13);

        // beq x0,x0,-4 replacing the head in the same cycle it is popped
        in_instr = 32'hFE000EE3;
        in_pc    = 32'h104;
        tick();
        chk("beq_valid",  64'(out_valid),  64'd1);
        chk("beq_imm",    64'(out_imm),    64'hFFFFFFFC);
        chk("beq_fmt",    64'(out_fmt),    64'd3);
        chk("beq_pc",     64'(out_pc),     64'h104);
        chk("beq_funct7", 64'(out_funct7), 64'h7F);

        // All-zero word is illegal
        in_instr = 32'h00000000;
        in_pc    = 32'h108;
        tick();
        chk("zero_valid",   64'(out_valid),   64'd1);
        chk("zero_illegal", 64'(out_illegal), 64'd1);
        chk("zero_imm",     64'(out_imm),     64'd0);
        chk("zero_fmt",     64'(out_fmt),     64'd6);

        // Decode table
        for (int i = 0; i < 12; i++) begin
            in_instr = tv_instr[i];
            in_pc    = 32'h180 + 32'(4 * i);
            tick();
            chk($sformatf("tv%0d_pc", i),      64'(out_pc),      64'(32'h180 + 32'(4 * i)));
            chk($sformatf("tv%0d_fmt", i),     64'(out_fmt),     64'(tv_fmt[i]));
            chk($sformatf("tv%0d_imm", i),     64'(out_imm),     64'(tv_imm[i]));
            chk($sformatf("tv%0d_illegal", i), 64'(out_illegal), 64'(tv_ill[i]));
        end
        in_valid = 1'b0;
        tick();
        chk("drain_empty", 64'(out_valid), 64'd0);

        // Stream of 6 with out_ready held low for 3 cycles
        sent     = 0;
        got      = 0;
        saw_full = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (got == 6) break;
            out_ready = !((c >= 1) && (c <= 3));
            in_valid  = (sent < 6);
            in_instr  = 32'((sent + 1) << 20) | 32'((sent + 1) << 7) | 32'h13;
            in_pc     = 32'h200 + 32'(4 * sent);
            #3;
            if (!in_ready) saw_full = 1'b1;
            if (out_valid && out_ready) begin
                chk($sformatf("stream%0d_pc", got),  64'(out_pc),  64'(32'h200 + 32'(4 * got)));
                chk($sformatf("stream%0d_imm", got), 64'(out_imm), 64'(got + 1));
                got++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        chk("stream_count", 64'(got), 64'd6);
        chk("stream_full",  64'(saw_full), 64'd1);
        chk("stream_empty", 64'(out_valid), 64'd0);

        // Fill to two entries, then flush with a concurrent push
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        in_pc     = 32'h300;
        tick();
        in_pc = 32'h304;
        tick();
        chk("two_in_ready",  64'(in_ready),  64'd0);
        chk("two_out_valid", 64'(out_valid), 64'd1);
        chk("two_head_pc",   64'(out_pc),    64'h300);
        flush = 1'b1;
        in_pc = 32'h308;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready",  64'(in_ready),  64'd1);
        out_ready = 1'b1;
        tick();
        tick();
        chk("flush_no_reappear", 64'(out_valid), 64'd0);

        // Flush in one-entry state with concurrent push and pop
        in_valid = 1'b1;
        in_pc    = 32'h30C;
        tick();
        chk("one_pc", 64'(out_pc), 64'h30C);
        flush = 1'b1;
        in_pc = 32'h310;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush1_out_valid", 64'(out_valid), 64'd0);
        in_valid = 1'b1;
        in_pc    = 32'h314;
        tick();
        in_valid = 1'b0;
        chk("post_flush_valid", 64'(out_valid), 64'd1);
        chk("post_flush_pc",    64'(out_pc),    64'h314);
        tick();
        chk("post_flush_empty", 64'(out_valid), 64'd0);

        // 64-bit instances: lui sign extension, ld and addw legality
        d_out_ready = 1'b0;
        d_in_valid  = 1'b1;
        d_instr     = 32'h800000B7;
        d_pc        = 64'h1000;
        tick();
        chk("lui64_imm",  a_imm,           64'hFFFFFFFF80000000);
        chk("lui64_fmt",  64'(a_fmt),      64'd4);
        chk("lui64_rd",   64'(a_rd),       64'd1);
        chk("lui64_pc",   a_pc,            64'h1000);
        chk("lui64r_imm", b_imm,           64'hFFFFFFFF80000000);
        d_out_ready = 1'b1;
        d_instr     = 32'h0000B083;
        d_pc        = 64'h1004;
        tick();
        chk("ld64_illegal",  64'(a_illegal), 64'd1);
        chk("ld64_fmt",      64'(a_fmt),     64'd6);
        chk("ld64r_illegal", 64'(b_illegal), 64'd0);
        chk("ld64r_fmt",     64'(b_fmt),     64'd1);
        chk("ld64r_funct3",  64'(b_funct3),  64'd3);
        d_instr = 32'h0000003B;
        d_pc    = 64'h1008;
        tick();
        chk("addw64_illegal",  64'(a_illegal), 64'd1);
        chk("addw64r_illegal", 64'(b_illegal), 64'd0);
        chk("addw64r_fmt",     64'(b_fmt),     64'd0);
        d_in_valid = 1'b0;
        tick();

        // Reset while one entry is held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h00100093;
        in_pc     = 32'h400;
        tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready),  64'd0);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        chk("post_rst_valid",    64'(out_valid), 64'd0);
        chk("post_rst_in_ready", 64'(in_ready),  64'd1);
        in_valid = 1'b1;
        in_pc    = 32'h404;
        tick();
        in_valid = 1'b0;
        chk("post_rst_push_valid", 64'(out_valid), 64'd1);
        chk("post_rst_push_pc",    64'(out_pc),    64'h404);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
